inst_cache_assoc: RTL and testbench
===================================

Name: inst_cache_assoc

Overview:
Parametrised set-associative instruction cache between the IF stage and MemCtrl. It has 1 or 2 ways and multi-word lines, and refills a full line word-by-word through the MemCtrl instruction channel. Hits are combinational, so IF can fetch one instruction per cycle. It adds a flush input (fence.i), LRU replacement, and hit/miss performance counters.

Parameters:
ADDR_WIDTH, 32, byte-address width.
INST_WIDTH, 32, instruction/word width.
INDEX_BITS, 4, log2(number of sets).
LINE_WORDS, 4, words per line; power of 2, at least 1.
WAYS, 2, associativity; only 1 or 2 are legal, any other value is an elaboration error.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset.
rdy  in  1  global ready; low freezes the block.
flush  in  1  one-cycle pulse; invalidates all lines.
IF_inst_read_valid  in  1  IF fetch request; held until IF_inst_valid.
IF_inst_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] are ignored.
IF_inst_valid  out  1  instruction returned this cycle.
IF_inst  out  INST_WIDTH  returned instruction.
MemCtrl_inst_valid  in  1  refill word returned this cycle.
MemCtrl_inst  in  INST_WIDTH  refill word.
MemCtrl_inst_read_valid  out  1  refill word request.
MemCtrl_inst_addr  out  ADDR_WIDTH  word-aligned byte address of the requested word.
stat_hits  out  32  hit count.
stat_misses  out  32  miss count.

Behaviour:
- Address split, with WO=log2(LINE_WORDS):
  - word offset = addr[WO+1:2]
  - index = addr[WO+INDEX_BITS+1:WO+2]
  - tag = the remaining upper bits
- Storage per set and way: valid bit, tag, and LINE_WORDS data words. Each set also holds one LRU bit (only meaningful when WAYS=2).
- Reset (rst=0, asynchronous):
  - all valid bits 0, LRU bits 0, state IDLE, refill counter 0, flush_pending 0, both counters 0
  - all outputs 0
- Freeze: when rdy=0, no state, array or counter changes. IF_inst_valid=0. MemCtrl outputs hold their values. MemCtrl_inst_valid is ignored.
- FSM states: IDLE and REFILL.
- IDLE, with rdy=1, IF_inst_read_valid=1 and flush=0:
  - Hit (a valid way with matching tag): in the same cycle (combinational), IF_inst_valid=1 and IF_inst=the addressed word.
  - On the hit edge: set LRU to the other way and increment stat_hits.
  - Miss: IF_inst_valid=0. On the edge:
    - latch the line base address (offset cleared) and the victim way
    - victim choice: the lowest invalid way, else the LRU way
    - counter←0, state←REFILL, stat_misses++
- REFILL:
  - MemCtrl_inst_read_valid=1 and MemCtrl_inst_addr=line_base+4*counter.
  - Each cycle with MemCtrl_inst_valid=1 writes MemCtrl_inst into victim word[counter], then counter++. The address advances in the following cycle.
  - After the last word (counter=LINE_WORDS-1):
    - write the tag
    - set valid=1, unless flush_pending
    - set LRU to the non-victim way
    - clear flush_pending, state←IDLE
  - MemCtrl_inst_read_valid is 0 in the cycle after the final response.
  - The victim's valid bit is cleared at refill start, so a partially written line never hits.
  - IF_inst_valid=0 throughout REFILL; no lookups occur.
  - If IF keeps requesting the same address, it hits in the first IDLE cycle. Miss latency is LINE_WORDS responses plus one cycle.
- IF withdraws its request (request dropped or address changed) during REFILL: the refill still completes and the line is installed. No instruction is returned for the dropped request.
- flush=1 (rdy=1):
  - IF_inst_valid is forced to 0 that cycle and no miss is started; flush beats a simultaneous miss.
  - On the edge all valid bits are cleared.
  - If in REFILL: flush_pending←1. The refill finishes but the line is not validated.
- Counters wrap modulo 2^32.
- In IDLE, when not hitting: IF_inst=0, MemCtrl_inst_read_valid=0, MemCtrl_inst_addr=0.

Test Plan:
1. Reset, then request 0x00001000. Required: miss; MemCtrl addresses 0x1000, 0x1004, 0x1008, 0x100C in order, answered with data A0..A3. Next IDLE cycle: IF_inst_valid=1, IF_inst=A0, stat_misses=1. Then request 0x1008: same-cycle hit, IF_inst=A2, stat_hits=2.
2. LRU, using the same-set addresses 0x1000, 0x1100 and 0x1200. Fill 0x1000, then 0x1100, then hit 0x1000, then request 0x1200. Required: the 0x1200 refill evicts 0x1100. Afterwards 0x1000 hits, 0x1100 misses, and stat_misses=4.
3. Flush during REFILL of 0x2000 after 2 words. Required: the refill completes all 4 words. A following request to 0x2000 misses again, and the earlier-filled 0x1000 misses too.
4. Hold rdy=0 for 5 cycles mid-refill, pulsing MemCtrl_inst_valid during the stall. Required: the counter and address are unchanged and the stalled pulse is not written. The refill resumes correctly once rdy=1.
5. Assert rst=0 asynchronously (not on a clock edge) mid-refill. Required: outputs are 0 immediately. After release, a request to the previously filled 0x1000 misses and the counters are 0.
6. Drop IF_inst_read_valid after the first refill word of 0x3000. Required: no IF_inst_valid pulse, and a later request to 0x3004 hits.

Source files
------------

// File: rtl/inst_cache_assoc.sv
// Set-associative instruction cache (1 or 2 ways) with combinational hits,
// word-by-word line refill from MemCtrl, fence.i flush, LRU and hit/miss counters.
module inst_cache_assoc #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32,
   parameter int INDEX_BITS = 4,
   parameter int LINE_WORDS = 4,
   parameter int WAYS       = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  flush,
   input  logic                  IF_inst_read_valid,
   input  logic [ADDR_WIDTH-1:0] IF_inst_addr,
   output logic                  IF_inst_valid,
   output logic [INST_WIDTH-1:0] IF_inst,
   input  logic                  MemCtrl_inst_valid,
   input  logic [INST_WIDTH-1:0] MemCtrl_inst,
   output logic                  MemCtrl_inst_read_valid,
   output logic [ADDR_WIDTH-1:0] MemCtrl_inst_addr,
   output logic [31:0]           stat_hits,
   output logic [31:0]           stat_misses
);

   localparam int WO    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 0;
   localparam int CW    = (WO > 0) ? WO : 1;
   localparam int SETS  = 1 << INDEX_BITS;
   localparam int TAG_W = ADDR_WIDTH - WO - INDEX_BITS - 2;

   if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
      $error("inst_cache_assoc: WAYS must be 1 or 2");
   end

   typedef enum logic {IDLE, REFILL} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic                    vway_q, vway_d;
   logic                    fp_q, fp_d;
   logic [31:0]             hits_q, hits_d;
   logic [31:0]             misses_q, misses_d;
   logic [SETS-1:0]         valid_q [WAYS];
   logic [SETS-1:0]         valid_d [WAYS];
   logic [SETS-1:0]         lru_q, lru_d;
   logic [TAG_W-1:0]        tag_q  [WAYS][SETS];
   logic [INST_WIDTH-1:0]   data_q [WAYS][SETS][LINE_WORDS];

   logic [CW-1:0]           req_off;
   logic [INDEX_BITS-1:0]   req_idx, ref_idx;
   logic [TAG_W-1:0]        req_tag, ref_tag;
   logic                    lookup, hit, hit_way, victim, last_word;
   logic                    data_we, tag_we;

   assign req_off = CW'((IF_inst_addr >> 2) & ADDR_WIDTH'(LINE_WORDS - 1));
   assign req_idx = INDEX_BITS'(IF_inst_addr >> (WO + 2));
   assign req_tag = TAG_W'(IF_inst_addr >> (WO + INDEX_BITS + 2));
   assign ref_idx = INDEX_BITS'(base_q >> (WO + 2));
   assign ref_tag = TAG_W'(base_q >> (WO + INDEX_BITS + 2));

   assign lookup    = (state_q == IDLE) && rdy && IF_inst_read_valid && !flush;
   assign last_word = (cnt_q == CW'(LINE_WORDS - 1));

   always_comb begin
      hit     = 1'b0;
      hit_way = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
            hit     = 1'b1;
            hit_way = 1'(w);
         end
      end
   end

   // Lowest invalid way wins; with both ways valid, evict the LRU way.
   always_comb begin
      victim = (WAYS == 2) ? lru_q[req_idx] : 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][req_idx]) victim = 1'(w);
      end
   end

   assign IF_inst_valid           = lookup && hit;
   assign IF_inst                 = IF_inst_valid ? data_q[hit_way][req_idx][req_off] : '0;
   assign MemCtrl_inst_read_valid = (state_q == REFILL);
   assign MemCtrl_inst_addr       = (state_q == REFILL) ? base_q + (ADDR_WIDTH'(cnt_q) << 2) : '0;
   assign stat_hits               = hits_q;
   assign stat_misses             = misses_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      base_d   = base_q;
      vway_d   = vway_q;
      fp_d     = fp_q;
      hits_d   = hits_q;
      misses_d = misses_q;
      valid_d  = valid_q;
      lru_d    = lru_q;
      data_we  = 1'b0;
      tag_we   = 1'b0;
      if (rdy) begin
         case (state_q)
            IDLE: begin
               if (lookup && hit) begin
                  lru_d[req_idx] = ~hit_way;
                  hits_d         = hits_q + 32'd1;
               end else if (lookup) begin
                  base_d                  = IF_inst_addr & ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);
                  vway_d                  = victim;
                  cnt_d                   = '0;
                  state_d                 = REFILL;
                  misses_d                = misses_q + 32'd1;
                  valid_d[victim][req_idx] = 1'b0;
               end
            end
            REFILL: begin
               if (MemCtrl_inst_valid) begin
                  data_we = 1'b1;
                  cnt_d   = cnt_q + CW'(1);
                  if (last_word) begin
                     tag_we                  = 1'b1;
                     valid_d[vway_q][ref_idx] = !(fp_q || flush);
                     lru_d[ref_idx]          = ~vway_q;
                     fp_d                    = 1'b0;
                     cnt_d                   = '0;
                     state_d                 = IDLE;
                  end
               end
               if (flush && !(MemCtrl_inst_valid && last_word)) fp_d = 1'b1;
            end
            default: state_d = IDLE;
         endcase
         if (flush) begin
            for (int w = 0; w < WAYS; w++) valid_d[w] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         base_q   <= '0;
         vway_q   <= 1'b0;
         fp_q     <= 1'b0;
         hits_q   <= '0;
         misses_q <= '0;
         lru_q    <= '0;
         for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         base_q   <= base_d;
         vway_q   <= vway_d;
         fp_q     <= fp_d;
         hits_q   <= hits_d;
         misses_q <= misses_d;
         lru_q    <= lru_d;
         valid_q  <= valid_d;
      end
   end

   // Line storage needs no reset: the valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (data_we) data_q[vway_q][ref_idx][cnt_q] <= MemCtrl_inst;
      if (tag_we)  tag_q[vway_q][ref_idx]         <= ref_tag;
   end

endmodule

// File: tb/tb_inst_cache_assoc.sv
// Scoreboard bench for inst_cache_assoc: a MemCtrl responder model, queued
// expectations for IF returns and refill addresses, and directed scenarios.
module tb_inst_cache_assoc;

   localparam logic [31:0] POISON = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        flush = 1'b0;
   logic        req = 1'b0;
   logic [31:0] addr = '0;
   logic        IF_inst_valid;
   logic [31:0] IF_inst;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_data = '0;
   logic        mem_rv;
   logic [31:0] mem_addr;
   logic [31:0] stat_hits, stat_misses;

   int          n_checks = 0;
   int          n_fail = 0;
   int          resp_cnt = 0;
   logic [31:0] if_q[$];
   logic [31:0] addr_q[$];

   always #5 clk = ~clk;

   inst_cache_assoc dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .IF_inst_read_valid(req), .IF_inst_addr(addr),
      .IF_inst_valid(IF_inst_valid), .IF_inst(IF_inst),
      .MemCtrl_inst_valid(mem_valid), .MemCtrl_inst(mem_data),
      .MemCtrl_inst_read_valid(mem_rv), .MemCtrl_inst_addr(mem_addr),
      .stat_hits(stat_hits), .stat_misses(stat_misses)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory answers every request at once; while frozen it returns poison.
   always begin
      @(posedge clk);
      #2;
      mem_valid = mem_rv;
      mem_data  = rdy ? mem_word(mem_addr) : POISON;
   end

   always @(negedge clk) begin
      if (rst && IF_inst_valid) begin
         if (if_q.size() == 0) chk("unexpected_if_valid", {31'd0, IF_inst_valid}, 32'd0);
         else chk("if_inst", IF_inst, if_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst && rdy && mem_valid && mem_rv) begin
         resp_cnt++;
         if (addr_q.size() == 0) chk("unexpected_mem_req", mem_addr, 32'hFFFF_FFFF);
         else chk("mem_addr", mem_addr, addr_q.pop_front());
      end
   end

   task automatic push_line(input logic [31:0] base);
      for (int i = 0; i < 4; i++) addr_q.push_back(base + 32'(4 * i));
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0; flush = 1'b0; rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_if_valid", {31'd0, IF_inst_valid}, 32'd0);
      chk("rst_rv", {31'd0, mem_rv}, 32'd0);
      chk("rst_hits", stat_hits, 32'd0);
      chk("rst_misses", stat_misses, 32'd0);
      if_q.delete();
      addr_q.delete();
      rst = 1'b1;
   endtask

   task automatic fetch(input logic [31:0] a, input bit miss);
      logic [31:0] m0, h0;
      int lat;
      m0 = stat_misses;
      h0 = stat_hits;
      if (miss) push_line(a & ~32'hF);
      if_q.push_back(mem_word(a & ~32'h3));
      @(posedge clk); #1;
      req = 1'b1; addr = a;
      lat = 0;
      @(negedge clk);
      while (!IF_inst_valid && lat < 100) begin
         lat++;
         @(negedge clk);
      end
      chk("fetch_latency", 32'(lat), miss ? 32'd5 : 32'd0);
      @(posedge clk); #1;
      req = 1'b0;
      chk("fetch_misses", stat_misses, m0 + {31'd0, miss});
      chk("fetch_hits", stat_hits, h0 + 32'd1);
   endtask

   task automatic wait_resp(input int target);
      int t = 0;
      while (resp_cnt < target && t < 100) begin
         @(negedge clk); #1;
         t++;
      end
      chk("resp_wait", 32'(resp_cnt), 32'(target));
   endtask

   task automatic wait_idle();
      int t = 0;
      while (mem_rv && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("refill_done", {31'd0, mem_rv}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int r0, t;
      // basic miss then hit in the same line
      do_reset();
      fetch(32'h1000, 1'b1);
      fetch(32'h1008, 1'b0);
      chk("t1_hits", stat_hits, 32'd2);
      chk("t1_misses", stat_misses, 32'd1);

      // LRU replacement within one set
      do_reset();
      fetch(32'h1000, 1'b1);
      fetch(32'h1100, 1'b1);
      fetch(32'h1000, 1'b0);
      fetch(32'h1200, 1'b1);
      fetch(32'h1000, 1'b0);
      fetch(32'h1100, 1'b1);
      chk("t2_misses", stat_misses, 32'd4);

      // flush during refill
      do_reset();
      fetch(32'h1000, 1'b1);
      r0 = resp_cnt;
      push_line(32'h2000);
      @(posedge clk); #1;
      req = 1'b1; addr = 32'h2000;
      wait_resp(r0 + 2);
      @(posedge clk); #1;
      flush = 1'b1; req = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      wait_idle();
      chk("t3_refill_words", 32'(resp_cnt), 32'(r0 + 4));
      fetch(32'h2000, 1'b1);
      fetch(32'h1000, 1'b1);
      chk("t3_misses", stat_misses, 32'd4);
      chk("t3_hits", stat_hits, 32'd3);

      // freeze mid-refill with poisoned responses
      do_reset();
      r0 = resp_cnt;
      push_line(32'h1000);
      if_q.push_back(mem_word(32'h1000));
      @(posedge clk); #1;
      req = 1'b1; addr = 32'h1000;
      wait_resp(r0 + 2);
      @(posedge clk); #1;
      rdy = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("stall_if_valid", {31'd0, IF_inst_valid}, 32'd0);
         chk("stall_addr", mem_addr, 32'h1008);
      end
      @(posedge clk); #1;
      rdy = 1'b1;
      t = 0;
      while (!IF_inst_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("stall_fetch_done", {31'd0, IF_inst_valid}, 32'd1);
      @(posedge clk); #1;
      req = 1'b0;
      fetch(32'h1008, 1'b0);
      fetch(32'h100C, 1'b0);

      // asynchronous reset mid-refill
      r0 = resp_cnt;
      push_line(32'h2000);
      @(posedge clk); #1;
      req = 1'b1; addr = 32'h2000;
      wait_resp(r0 + 2);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_rv", {31'd0, mem_rv}, 32'd0);
      chk("arst_addr", mem_addr, 32'd0);
      chk("arst_if_valid", {31'd0, IF_inst_valid}, 32'd0);
      chk("arst_if_inst", IF_inst, 32'd0);
      chk("arst_hits", stat_hits, 32'd0);
      req = 1'b0;
      addr_q.delete();
      if_q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      chk("arst_misses", stat_misses, 32'd0);
      fetch(32'h1000, 1'b1);

      // IF withdraws during refill
      do_reset();
      r0 = resp_cnt;
      push_line(32'h3000);
      @(posedge clk); #1;
      req = 1'b1; addr = 32'h3000;
      wait_resp(r0 + 1);
      @(posedge clk); #1;
      req = 1'b0;
      wait_idle();
      chk("t6_refill_words", 32'(resp_cnt), 32'(r0 + 4));
      fetch(32'h3004, 1'b0);
      chk("t6_misses", stat_misses, 32'd1);

      repeat (2) @(posedge clk);
      chk("if_queue_empty", 32'(if_q.size()), 32'd0);
      chk("addr_queue_empty", 32'(addr_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
